mixcolumn_engine: RTL

MIXCOLUMN_ENGINE -- requirements
Module: mixcolumn_engine

---
 rtl/mixcolumn_engine.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mixcolumn_engine.sv
// AES MixColumns engine: transforms NCOL 32-bit columns in place, one column per cycle.
// Define MIXCOL_INV_EN to compile in the InvMixColumns datapath (in_inv honoured).
module mixcolumn_engine #(
  parameter int NCOL = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NCOL-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NCOL-1:0] out_data,
  output logic               busy
);
  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int W  = 32 * NCOL;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [31:0]     col_cur, col_new;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] d [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = c[8*i +: 8];
      d[i] = xt(a[i]);
    end
    return {d[0] ^ a[0] ^ a[1] ^ a[2] ^ d[3],
            a[0] ^ a[1] ^ d[2] ^ d[3] ^ a[3],
            a[0] ^ d[1] ^ d[2] ^ a[2] ^ a[3],
            d[0] ^ d[1] ^ a[1] ^ a[2] ^ a[3]};
  endfunction

`ifdef MIXCOL_INV_EN
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] a, x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a  = c[8*i +: 8];
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            me[0] ^ mb[1] ^ md[2] ^ m9[3]};
  endfunction

  assign col_new = mode_q ? inv_col(col_cur) : fwd_col(col_cur);
`else
  logic unused_mode;
  assign unused_mode = ^{in_inv, mode_q};
  assign col_new     = fwd_col(col_cur);
`endif

  always_comb begin
    col_cur = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (cnt_q == CW'(c)) col_cur = work_q[32*c +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = in_data;
          cnt_d   = '0;
`ifdef MIXCOL_INV_EN
          mode_d  = in_inv;
`else
          mode_d  = 1'b0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int c = 0; c < NCOL; c++) begin
          if (cnt_q == CW'(c)) work_d[32*c +: 32] = col_new;
        end
        // Result register only updates on completion so out_data survives the next block's BUSY phase.
        if (cnt_q == CW'(NCOL - 1)) begin
          res_d   = work_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;

endmodule
